// File: rtl/grf_writeback.sv
// W-stage write-back: selects write data, commits it to the 32x32 register file,
// serves two bypassed D-stage read ports and keeps a one-cycle commit record plus
// a retired-instruction counter for trace comparison.
module grf_writeback #(
    parameter logic [7:0]  NOP_TYPE = 8'd0,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Pc_W,
    input  logic [31:0] AluAns_W,
    input  logic [31:0] DmAns_W,
    input  logic [4:0]  WR_W,
    input  logic [1:0]  MemToReg_W,
    input  logic        RegWrite_W,
    input  logic [7:0]  InstrType_W,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic [31:0] WD_W,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [31:0] retire_cnt
);

    // Register storage; entry 0 is never written and never read back.
    logic [31:0] grf_r [32];

    logic [31:0] wd_s;
    logic        we_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;

    logic        wb_valid_r;
    logic [31:0] wb_pc_r;
    logic [4:0]  wb_reg_r;
    logic [31:0] wb_data_r;
    logic [31:0] retire_cnt_r;

    // Write-data select; the link value is PC+8 and the reserved code yields zero.
    always_comb begin
        wd_s = 32'h0000_0000;
        case (MemToReg_W)
            2'd0:    wd_s = AluAns_W;
            2'd1:    wd_s = DmAns_W;
            2'd2:    wd_s = Pc_W + 32'd8;
            default: wd_s = 32'h0000_0000;
        endcase
    end

    // A commit needs an enabled write to a real register outside the reset cycle.
    always_comb begin
        if (RegWrite_W && (WR_W != 5'd0) && !reset) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Read port 1: $0 is hard zero, otherwise write-through bypass of this edge's write.
    always_comb begin
        rd1_s = 32'h0000_0000;
        if (A1_D == 5'd0) begin
            rd1_s = 32'h0000_0000;
        end else if (we_s && (WR_W == A1_D)) begin
            rd1_s = wd_s;
        end else begin
            rd1_s = grf_r[A1_D];
        end
    end

    // Read port 2: same rules as port 1, independent address.
    always_comb begin
        rd2_s = 32'h0000_0000;
        if (A2_D == 5'd0) begin
            rd2_s = 32'h0000_0000;
        end else if (we_s && (WR_W == A2_D)) begin
            rd2_s = wd_s;
        end else begin
            rd2_s = grf_r[A2_D];
        end
    end

    // Register file update: reset clears every entry, otherwise commit the selected data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_r[i] <= 32'h0000_0000;
            end
        end else if (we_s) begin
            grf_r[WR_W] <= wd_s;
        end
    end

    // Commit record: valid pulses per commit, payload holds until the next commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_r <= 1'b0;
            wb_pc_r    <= RESET_PC;
            wb_reg_r   <= 5'd0;
            wb_data_r  <= 32'h0000_0000;
        end else begin
            wb_valid_r <= we_s;
            if (we_s) begin
                wb_pc_r   <= Pc_W;
                wb_reg_r  <= WR_W;
                wb_data_r <= wd_s;
            end
        end
    end

    // Retired-instruction counter: every non-bubble W slot counts, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_r <= 32'h0000_0000;
        end else if (InstrType_W != NOP_TYPE) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end
    end

    assign WD_W       = wd_s;
    assign RD1_D      = rd1_s;
    assign RD2_D      = rd2_s;
    assign wb_valid   = wb_valid_r;
    assign wb_pc      = wb_pc_r;
    assign wb_reg     = wb_reg_r;
    assign wb_data    = wb_data_r;
    assign retire_cnt = retire_cnt_r;

endmodule
